// File: rtl/reg_file_ctrl_pkg.sv
// Shared types and command codes for the register-file command controller.
// No logic here; consumed by reg_file_ctrl.
// No flow control of its own.
package reg_file_ctrl_pkg;

    // Controller states; IDLE is the only non-busy state.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_WR_EXEC = 3'd3,
        ST_RD_ADDR = 3'd4,
        ST_RD_EXEC = 3'd5,
        ST_TX_SEND = 3'd6
    } ctrl_state_t;

    // Frame command bytes; widened to the data width at the point of use.
    localparam logic [7:0] CMD_WRITE = 8'hAA;
    localparam logic [7:0] CMD_READ  = 8'hBB;

endpackage

// File: rtl/reg_file_ctrl.sv
// Parses framed UART bytes into single-cycle register-file write/read strobes; returns read data.
// Latency: write strobe 1 cycle after data byte; read strobe 1 cycle after addr byte, tx valid 1 cycle later.
// Backpressure: o_tx_valid/o_tx_data held until i_tx_ready; rx bytes arriving while executing are dropped and flagged.
module reg_file_ctrl
    import reg_file_ctrl_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int DEPTH_BUS = $clog2(DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [WIDTH-1:0]     i_rx_data,
    input  logic                 i_rx_valid,
    output logic                 o_rf_write_enable,
    output logic                 o_rf_read_enable,
    output logic [DEPTH_BUS-1:0] o_rf_address,
    output logic [WIDTH-1:0]     o_rf_write_data,
    input  logic [WIDTH-1:0]     i_rf_read_data,
    input  logic                 i_rf_rd_valid,
    output logic [WIDTH-1:0]     o_tx_data,
    output logic                 o_tx_valid,
    input  logic                 i_tx_ready,
    output logic                 o_busy,
    output logic                 o_cmd_error
);

    // Command codes zero-extended to the byte width.
    localparam logic [WIDTH-1:0] CMD_WR_W = WIDTH'(CMD_WRITE);
    localparam logic [WIDTH-1:0] CMD_RD_W = WIDTH'(CMD_READ);

    ctrl_state_t          state_q, state_d;
    logic [DEPTH_BUS-1:0] addr_q,  addr_d;
    logic [WIDTH-1:0]     wdata_q, wdata_d;
    logic [WIDTH-1:0]     txd_q,   txd_d;
    logic                 err_q,   err_d;
    logic                 addr_ovf;

    // An address byte is out of range when any bit above the address field is set.
    assign addr_ovf = ((i_rx_data >> DEPTH_BUS) != '0);

    // Next-state, datapath capture and error decode from the registered state.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        txd_d   = txd_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_rx_valid) begin
                    if (i_rx_data == CMD_WR_W) begin
                        state_d = ST_WR_ADDR;
                    end else if (i_rx_data == CMD_RD_W) begin
                        state_d = ST_RD_ADDR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_WR_ADDR, ST_RD_ADDR: begin
                if (i_rx_valid) begin
                    // Address is latched even when rejected; only the strobe is suppressed.
                    addr_d = i_rx_data[DEPTH_BUS-1:0];
                    if (addr_ovf) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else if (state_q == ST_WR_ADDR) begin
                        state_d = ST_WR_DATA;
                    end else begin
                        state_d = ST_RD_EXEC;
                    end
                end
            end
            ST_WR_DATA: begin
                if (i_rx_valid) begin
                    wdata_d = i_rx_data;
                    state_d = ST_WR_EXEC;
                end
            end
            ST_WR_EXEC: begin
                err_d   = i_rx_valid;
                state_d = ST_IDLE;
            end
            ST_RD_EXEC: begin
                // A read the register file does not validate is reported, not transmitted.
                if (i_rf_rd_valid) begin
                    txd_d   = i_rf_read_data;
                    state_d = ST_TX_SEND;
                    err_d   = i_rx_valid;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_TX_SEND: begin
                err_d = i_rx_valid;
                if (i_tx_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset wins over any concurrent rx or tx event.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            txd_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            txd_q   <= txd_d;
            err_q   <= err_d;
        end
    end

    // Strobes and status decode straight from the registered state, so they are one-hot by construction.
    assign o_rf_write_enable = (state_q == ST_WR_EXEC);
    assign o_rf_read_enable  = (state_q == ST_RD_EXEC);
    assign o_tx_valid        = (state_q == ST_TX_SEND);
    assign o_busy            = (state_q != ST_IDLE);
    assign o_rf_address      = addr_q;
    assign o_rf_write_data   = wdata_q;
    assign o_tx_data         = txd_q;
    assign o_cmd_error       = err_q;

endmodule
